// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, reserved register indices and word/index types for the
// scoreboarded integer register file.
package rf_pkg;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int AW = $clog2(NREGS);
    localparam int REG_ZERO = 0;
    localparam int REG_SP = 2;
    localparam logic [31:0] SP_RESET_VAL = 32'h00000200;
    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0] xword_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits (set beats clear) and per-port busy lookup.
// With RF_BYPASS_EN defined, a same-cycle clearing write hides the busy bit from readers.
module rf_scoreboard import rf_pkg::*; #(
    parameter int NREGS = rf_pkg::NREGS,
    parameter int NRD = 2,
    localparam int AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rs,
    input  logic              wen0,
    input  logic [AW-1:0]     wa0,
    input  logic              wen1,
    input  logic [AW-1:0]     wa1,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_rd,
    output logic [NREGS-1:0]  busy_vec,
    output logic [NRD-1:0]    rbusy
);
    logic [NREGS-1:0] busy_d, busy_q;

    // Reservation is applied last so a new producer outlives a retiring one.
    always_comb begin
        busy_d = busy_q;
        if (wen0) busy_d[wa0] = 1'b0;
        if (wen1) busy_d[wa1] = 1'b0;
        if (rsv_en) busy_d[rsv_rd] = 1'b1;
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rbusy
        logic [AW-1:0] idx;
        assign idx = rs[k*AW +: AW];
`ifdef RF_BYPASS_EN
        logic fwd_clr;
        assign fwd_clr = (idx != '0) && ((wen1 && wa1 == idx) || (wen0 && wa0 == idx))
                         && !(rsv_en && rsv_rd == idx);
        assign rbusy[k] = busy_q[idx] && !fwd_clr;
`else
        assign rbusy[k] = busy_q[idx];
`endif
    end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: NRD-read, two-write register file with busy scoreboard.
// Define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_sb import rf_pkg::*; #(
    parameter int XLEN = rf_pkg::XLEN,
    parameter int NREGS = rf_pkg::NREGS,
    parameter int NRD = 2,
    parameter int SP_IDX = REG_SP,
    parameter logic [XLEN-1:0] SP_RESET = XLEN'(SP_RESET_VAL),
    localparam int AW = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                wen0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                wen1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_rd,
    output logic [NREGS-1:0]    busy_vec
);
    logic [XLEN-1:0] regs_d [NREGS];
    logic [XLEN-1:0] regs_q [NREGS];

    // Port 1 is applied after port 0 so it wins a same-index collision.
    always_comb begin
        regs_d = regs_q;
        if (wen0) regs_d[wa0] = wd0;
        if (wen1) regs_d[wa1] = wd1;
        regs_d[REG_ZERO] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] idx;
        assign idx = rs[k*AW +: AW];
`ifdef RF_BYPASS_EN
        assign rdata[k*XLEN +: XLEN] = (idx == '0) ? '0 :
                                       (wen1 && wa1 == idx) ? wd1 :
                                       (wen0 && wa0 == idx) ? wd0 : regs_q[idx];
`else
        assign rdata[k*XLEN +: XLEN] = regs_q[idx];
`endif
    end

    rf_scoreboard #(.NREGS(NREGS), .NRD(NRD)) u_sb (
        .clk(clk),
        .rst(rst),
        .rs(rs),
        .wen0(wen0),
        .wa0(wa0),
        .wen1(wen1),
        .wa1(wa1),
        .rsv_en(rsv_en),
        .rsv_rd(rsv_rd),
        .busy_vec(busy_vec),
        .rbusy(rbusy)
    );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb, either RF_BYPASS_EN build.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs0, rs1;
    logic [9:0]  rs;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        wen0, wen1, rsv_en;
    logic [4:0]  wa0, wa1, rsv_rd;
    logic [31:0] wd0, wd1;
    logic [31:0] busy_vec;
    logic [31:0] rdata0, rdata1;
    int checks = 0;
    int errors = 0;

    assign rs = {rs1, rs0};
    assign rdata0 = rdata[31:0];
    assign rdata1 = rdata[63:32];

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk(clk), .rst(rst), .rs(rs), .rdata(rdata), .rbusy(rbusy),
        .wen0(wen0), .wa0(wa0), .wd0(wd0),
        .wen1(wen1), .wa1(wa1), .wd1(wd1),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd), .busy_vec(busy_vec)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wen0 = 1'b0; wen1 = 1'b0; rsv_en = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; rsv_rd = '0;
    endtask

    task automatic test_reset();
        idle();
        rs0 = 5'd0; rs1 = 5'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rs0 = 5'd2; rs1 = 5'd5;
        #1;
        checks++; if (rdata0 !== 32'h200) begin errors++; $display("FAIL reset_sp: got %h exp %h", rdata0, 32'h200); end
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_x5: got %h exp %h", rdata1, 32'h0); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy_vec: got %h exp %h", busy_vec, 32'h0); end
        checks++; if (rbusy !== 2'b00) begin errors++; $display("FAIL reset_rbusy: got %b exp %b", rbusy, 2'b00); end
    endtask

    task automatic test_dual_write();
        wen0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA_0000;
        wen1 = 1'b1; wa1 = 5'd7; wd1 = 32'h0000_5555;
        tick();
        idle();
        rs0 = 5'd7;
        #1;
        checks++; if (rdata0 !== 32'h0000_5555) begin errors++; $display("FAIL collision_x7: got %h exp %h", rdata0, 32'h0000_5555); end
        wen0 = 1'b1; wa0 = 5'd8; wd0 = 32'h11;
        wen1 = 1'b1; wa1 = 5'd10; wd1 = 32'h22;
        tick();
        idle();
        rs0 = 5'd8; rs1 = 5'd10;
        #1;
        checks++; if (rdata0 !== 32'h11) begin errors++; $display("FAIL dual_x8: got %h exp %h", rdata0, 32'h11); end
        checks++; if (rdata1 !== 32'h22) begin errors++; $display("FAIL dual_x10: got %h exp %h", rdata1, 32'h22); end
    endtask

    task automatic test_x0();
        wen0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEAD_BEEF;
        wen1 = 1'b1; wa1 = 5'd0; wd1 = 32'hCAFE_F00D;
        rsv_en = 1'b1; rsv_rd = 5'd0;
        rs0 = 5'd0;
        #1;
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL x0_same_cycle: got %h exp %h", rdata0, 32'h0); end
        tick();
        idle();
        #1;
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL x0_read: got %h exp %h", rdata0, 32'h0); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL x0_busy_vec: got %h exp %h", busy_vec, 32'h0); end
        checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL x0_rbusy: got %b exp %b", rbusy[0], 1'b0); end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_rd = 5'd9;
        tick();
        idle();
        rs0 = 5'd8; rs1 = 5'd9;
        #1;
        checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL sb_set: got %h exp %h", busy_vec, 32'h0000_0200); end
        checks++; if (rbusy !== 2'b10) begin errors++; $display("FAIL sb_rbusy: got %b exp %b", rbusy, 2'b10); end
        // Unrelated write must not disturb the outstanding reservation.
        wen0 = 1'b1; wa0 = 5'd8; wd0 = 32'h33;
        tick();
        idle();
        tick();
        tick();
        checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL sb_hold: got %h exp %h", busy_vec, 32'h0000_0200); end
        wen1 = 1'b1; wa1 = 5'd9; wd1 = 32'h1234;
        #1;
`ifdef RF_BYPASS_EN
        checks++; if (rbusy[1] !== 1'b0) begin errors++; $display("FAIL sb_fwd_rbusy: got %b exp %b", rbusy[1], 1'b0); end
        checks++; if (rdata1 !== 32'h1234) begin errors++; $display("FAIL sb_fwd_data: got %h exp %h", rdata1, 32'h1234); end
`else
        checks++; if (rbusy[1] !== 1'b1) begin errors++; $display("FAIL sb_wb_rbusy: got %b exp %b", rbusy[1], 1'b1); end
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL sb_wb_old: got %h exp %h", rdata1, 32'h0); end
`endif
        tick();
        idle();
        #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL sb_clear: got %h exp %h", busy_vec, 32'h0); end
        checks++; if (rdata1 !== 32'h1234) begin errors++; $display("FAIL sb_x9: got %h exp %h", rdata1, 32'h1234); end
        checks++; if (rdata0 !== 32'h33) begin errors++; $display("FAIL sb_x8: got %h exp %h", rdata0, 32'h33); end
        rsv_en = 1'b1; rsv_rd = 5'd9;
        tick();
        rsv_en = 1'b1; rsv_rd = 5'd9;
        wen0 = 1'b1; wa0 = 5'd9; wd0 = 32'h77;
        #1;
        checks++; if (rbusy[1] !== 1'b1) begin errors++; $display("FAIL sb_rsv_wr_rbusy: got %b exp %b", rbusy[1], 1'b1); end
        tick();
        idle();
        #1;
        checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL sb_set_wins: got %h exp %h", busy_vec, 32'h0000_0200); end
        checks++; if (rdata1 !== 32'h77) begin errors++; $display("FAIL sb_set_wins_data: got %h exp %h", rdata1, 32'h77); end
        rsv_en = 1'b1; rsv_rd = 5'd9;
        tick();
        idle();
        wen0 = 1'b1; wa0 = 5'd9; wd0 = 32'h78;
        tick();
        idle();
        #1;
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL sb_no_count: got %h exp %h", busy_vec, 32'h0); end
    endtask

    task automatic test_bypass();
        rs0 = 5'd4; rs1 = 5'd4;
        wen0 = 1'b1; wa0 = 5'd4; wd0 = 32'h55;
        #1;
`ifdef RF_BYPASS_EN
        checks++; if (rdata0 !== 32'h55) begin errors++; $display("FAIL byp_same: got %h exp %h", rdata0, 32'h55); end
`else
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL byp_old: got %h exp %h", rdata0, 32'h0); end
`endif
        tick();
        idle();
        #1;
        checks++; if (rdata0 !== 32'h55) begin errors++; $display("FAIL byp_next: got %h exp %h", rdata0, 32'h55); end
        wen0 = 1'b1; wa0 = 5'd4; wd0 = 32'h66;
        wen1 = 1'b1; wa1 = 5'd4; wd1 = 32'h77;
        #1;
`ifdef RF_BYPASS_EN
        checks++; if (rdata1 !== 32'h77) begin errors++; $display("FAIL byp_prio: got %h exp %h", rdata1, 32'h77); end
`else
        checks++; if (rdata1 !== 32'h55) begin errors++; $display("FAIL byp_prio_old: got %h exp %h", rdata1, 32'h55); end
`endif
        tick();
        idle();
        #1;
        checks++; if (rdata1 !== 32'h77) begin errors++; $display("FAIL byp_prio_next: got %h exp %h", rdata1, 32'h77); end
    endtask

    task automatic test_reset_mid();
        rsv_en = 1'b1; rsv_rd = 5'd3;
        tick();
        rsv_rd = 5'd9;
        tick();
        idle();
        #1;
        checks++; if (busy_vec !== 32'h0000_0208) begin errors++; $display("FAIL rm_pre_busy: got %h exp %h", busy_vec, 32'h0000_0208); end
        rst = 1'b1;
        wen0 = 1'b1; wa0 = 5'd3; wd0 = 32'hABC;
        rsv_en = 1'b1; rsv_rd = 5'd5;
        tick();
        idle();
        rs0 = 5'd3; rs1 = 5'd7;
        #1;
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL rm_x3: got %h exp %h", rdata0, 32'h0); end
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL rm_x7: got %h exp %h", rdata1, 32'h0); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL rm_busy_vec: got %h exp %h", busy_vec, 32'h0); end
        rs0 = 5'd2; rs1 = 5'd9;
        #1;
        checks++; if (rdata0 !== 32'h200) begin errors++; $display("FAIL rm_sp: got %h exp %h", rdata0, 32'h200); end
        wen1 = 1'b1; wa1 = 5'd9; wd1 = 32'h99;
        tick();
        idle();
        #1;
        checks++; if (rdata1 !== 32'h99) begin errors++; $display("FAIL rm_late_write: got %h exp %h", rdata1, 32'h99); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL rm_late_busy: got %h exp %h", busy_vec, 32'h0); end
    endtask

    initial begin
        idle();
        rs0 = '0; rs1 = '0;
        test_reset();
        test_dual_write();
        test_x0();
        test_scoreboard();
        test_bypass();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single-write-port integer register file.
- Provides NRD read ports, two write ports (ALU writeback and late/load writeback) and a per-register busy scoreboard for multicycle and late results.
- Sits in the decode/writeback boundary of the RV32I core. Decode reads operands and busy flags; issue reserves rd; writeback ports retire results.

Parameters:
- XLEN, 32, register width in bits.
- NREGS, 32, number of architectural registers (power of 2, >= 4).
- AW, $clog2(NREGS), register index width (derived, not overridden).
- NRD, 2, number of read ports (1..4).
- SP_IDX, 2, index of stack pointer register.
- SP_RESET, 32'h00000200, stack pointer value after reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rs  in  NRD*AW  read indices, port k at bits [k*AW +: AW].
- rdata  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN].
- rbusy  out  NRD  port k source has an outstanding reservation.
- wen0  in  1  write enable, port 0 (ALU writeback).
- wa0  in  AW  write index, port 0.
- wd0  in  XLEN  write data, port 0.
- wen1  in  1  write enable, port 1 (load/late writeback).
- wa1  in  AW  write index, port 1.
- wd1  in  XLEN  write data, port 1.
- rsv_en  in  1  reserve rd at issue (sets busy).
- rsv_rd  in  AW  register to reserve.
- busy_vec  out  NREGS  full scoreboard, bit i = register i busy.

Behaviour:
- Reset:
  - When rst is high at a rising edge, all registers become 0, except register SP_IDX, which becomes SP_RESET.
  - All busy bits clear.
  - rst overrides any write or reservation in the same cycle.
  - A reservation in flight across reset is lost; a later write to that register is a normal write.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and reservations to index 0 are ignored.
- Reads:
  - Combinational from the array, zero latency.
  - rdata and rbusy are valid in the same cycle as rs.
- Writes:
  - Committed at the rising edge.
  - If both ports are enabled to the same index, port 1 wins and the port 0 data is discarded.
- Scoreboard:
  - Bit i sets on rsv_en with rsv_rd==i.
  - Bit i clears on any enabled write to i.
  - If a set and a clear of the same bit occur in one cycle, set wins (the new producer is outstanding).
  - A write to a non-busy register is legal and does not change busy.
  - A reservation of an already-busy register keeps the bit set; no counting.
- busy_vec reflects registered scoreboard state.
- rbusy[k] = busy_vec[rs_k], subject to the bypass rule under Optional Feature.
- Reset values after rst: rdata[k] = 0, or SP_RESET when rs_k==SP_IDX; rbusy = 0; busy_vec = 0.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Same-cycle write-to-read forwarding. If wen1 && wa1==rs_k && rs_k!=0, rdata[k]=wd1; else if wen0 && wa0==rs_k, rdata[k]=wd0; else array value.
  - rbusy[k] is forced 0 when the forwarded write clears that register, unless rsv_en reserves the same index this cycle.
- Undefined:
  - Reads return the pre-edge array value.
  - rbusy[k] is the registered busy bit only.
  - Write-then-read needs one cycle.

Decomposition:
- Package rf_pkg holds:
  - XLEN, NREGS and AW defaults.
  - REG_ZERO = 0, REG_SP = 2, SP_RESET_VAL = 32'h00000200.
  - typedef reg_idx_t (AW bits) and xword_t (XLEN bits).
- One sub-module, rf_scoreboard: busy bits with set/clear priority, busy_vec output, and bypass masking of rbusy.
- Array, write arbitration and read muxes stay in reg_file_sb.

Test Plan:
- Reset: assert rst 1 cycle, read rs0=2, rs1=5 -> rdata0=32'h200, rdata1=0, busy_vec=0.
- Dual write collision: wen0 wa0=7 wd0=32'hAAAA_0000 and wen1 wa1=7 wd1=32'h0000_5555 in one cycle -> next cycle read x7 = 32'h0000_5555.
- x0 protection: wen0 wa0=0 wd0=32'hDEAD_BEEF plus rsv_en rsv_rd=0 -> x0 reads 0, busy_vec[0]=0.
- Scoreboard: rsv_en rd=9 -> busy_vec[9]=1, rbusy on port reading x9. Three cycles later wen1 wa1=9 wd1=32'h1234 -> busy clears next cycle, x9=32'h1234. Reserve rd=9 and write x9 in the same cycle -> busy stays 1.
- Bypass: wen0 wa0=4 wd0=32'h55 with rs0=4 in the same cycle -> with RF_BYPASS_EN rdata0=32'h55 in that cycle; without it, the old value, then 32'h55 next cycle.
- Reset mid-operation: busy x3 and x9 set, rst asserted together with wen0 wa0=3 -> x3=0, busy_vec=0 afterwards.
